// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-client UART TX arbiter.
//   state_e : serializer frame state (idle, start bit, data bits, stop bit)
//   LF      : line-feed byte that releases a line lock
package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit, each held DIV cycles.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, aborts any frame in progress
//   load : accept data this cycle (only honoured while idle)
//   data : byte to send
//   idle : serializer can take a byte this cycle
//   tx   : serial line, high when idle
//   busy : start, data or stop bit on the line
module uart_tx_ser
    import uart_arb_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       idle,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            bit_end;

    assign bit_end = (div_q == DivLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idle    = 1'b0;
        tx      = 1'b1;
        busy    = 1'b1;

        unique case (state_q)
            StIdle: begin
                idle = 1'b1;
                busy = 1'b0;
                if (load) begin
                    shift_d = data;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx    = 1'b0;
                div_d = bit_end ? '0 : div_q + 1'b1;
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                tx    = shift_q[0];
                div_d = bit_end ? '0 : div_q + 1'b1;
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    // Counter wraps 7 -> 0 as the last data bit completes.
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                tx    = 1'b1;
                div_d = bit_end ? '0 : div_q + 1'b1;
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one 8N1 UART TX line between client 0 (CPU) and client 1 (debug).
// One byte is granted per frame; back-to-back frames are 10*DIV+1 cycles apart.
// Optional feature: define UART_ARB_LINE_LOCK_EN to keep the line with a client until it sends
// 0x0A or stays silent for LOCK_TIMEOUT idle cycles.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req0_data/valid/ready  : client 0 byte handshake
//   req1_data/valid/ready  : client 1 byte handshake
//   tx                     : serial line, idles high
//   busy                   : a frame is in progress
//   grant                  : client whose byte is on the line (or was last served)
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 24000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned DIV          = CLK_HZ / BAUD,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant
);

    if (DIV < 2 || LOCK_TIMEOUT == 0 || BAUD == 0 || CLK_HZ == 0) begin : g_bad_params
        $error("uart_tx_arb: DIV must be >= 2 and LOCK_TIMEOUT >= 1");
    end

    logic       idle;
    logic       elig0, elig1;
    logic       any_elig;
    logic       sel;
    logic       transfer;
    logic [7:0] load_data;
    logic       last_q;
    logic       grant_q;

`ifdef UART_ARB_LINE_LOCK_EN
    localparam int unsigned ToW = $clog2(LOCK_TIMEOUT + 1);

    logic           lock_q, lock_d;
    logic           lock_id_q, lock_id_d;
    logic [ToW-1:0] to_q, to_d;
    logic           lock_valid;

    // While locked, the other client is invisible to arbitration.
    assign elig0 = req0_valid && !(lock_q && lock_id_q);
    assign elig1 = req1_valid && !(lock_q && !lock_id_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            to_q      <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        to_d       = '0;
        lock_valid = lock_id_q ? req1_valid : req0_valid;
        if (transfer) begin
            lock_d    = (load_data != LF);
            lock_id_d = sel;
        end else if (idle && lock_q && !lock_valid) begin
            // Counts consecutive idle cycles with the owner silent; any break restarts it.
            if (to_q == ToW'(LOCK_TIMEOUT - 1)) begin
                lock_d = 1'b0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end
`else
    assign elig0 = req0_valid;
    assign elig1 = req1_valid;
`endif

    // On a tie the client not served last wins; otherwise whoever is asking.
    assign any_elig   = elig0 || elig1;
    assign sel        = (elig0 && elig1) ? ~last_q : elig1;
    assign req0_ready = idle && !rst && any_elig && !sel;
    assign req1_ready = idle && !rst && any_elig && sel;
    assign transfer   = req0_ready || req1_ready;
    assign load_data  = sel ? req1_data : req0_data;
    assign grant      = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 1'b1;
            grant_q <= 1'b0;
        end else if (transfer) begin
            last_q  <= sel;
            grant_q <= sel;
        end
    end

    uart_tx_ser #(
        .DIV (DIV)
    ) u_ser (
        .clk  (clk),
        .rst  (rst),
        .load (transfer),
        .data (load_data),
        .idle (idle),
        .tx   (tx),
        .busy (busy)
    );

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb at DIV=4 (CLK_HZ=460800, BAUD=115200).
// A frame-level reference model predicts ready/tx/busy/grant every cycle; a line decoder
// recovers the transmitted bytes independently of the handshake log.
module tb_uart_tx_arb;

    localparam int DIV_T  = 4;
    localparam int FRAME  = 10 * DIV_T;
    localparam int LOCK_T = 20;
`ifdef UART_ARB_LINE_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       req0_ready, req1_ready;
    logic       tx, busy, grant;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .CLK_HZ       (460800),
        .BAUD         (115200),
        .LOCK_TIMEOUT (LOCK_T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (d0),
        .req0_valid (v0),
        .req0_ready (req0_ready),
        .req1_data  (d1),
        .req1_valid (v1),
        .req1_ready (req1_ready),
        .tx         (tx),
        .busy       (busy),
        .grant      (grant)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int cyc = 0;

    // Stimulus sources
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int p0 = 0;
    int p1 = 0;

    // Handshakes observed on the DUT
    int         acc_cyc[$];
    bit         acc_cl[$];
    logic [7:0] acc_dat[$];
    int         busy_cnt = 0;

    // Reference model state
    int         free_at = 0;
    bit         m_last = 1'b1;
    bit         m_grant = 1'b0;
    bit         frame_on = 1'b0;
    int         acc_t = 0;
    logic [9:0] frame = '1;
    bit         m_locked = 1'b0;
    bit         m_lock_id = 1'b0;
    int         m_idle_cnt = 0;

    // Line decoder
    logic [7:0] rx_q[$];
    logic       rx_on = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            rx_on <= 1'b0;
            rx_t  <= 0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on <= 1'b1;
                rx_t  <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t >= DIV_T + DIV_T / 2 && rx_t < 9 * DIV_T && (rx_t % DIV_T) == DIV_T / 2)
                rx_sh <= {tx, rx_sh[7:1]};
            if (rx_t == 9 * DIV_T + DIV_T / 2) begin
                rx_q.push_back(rx_sh);
                rx_on <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        acc_cl.delete();
        acc_dat.delete();
        rx_q.delete();
        busy_cnt = 0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model.
    task automatic step(input bit do_rst);
        logic [7:0] b;
        bit e0, e1, s, any;
        logic exp_tx, exp_busy;
        rst = do_rst;
        v0  = (q0.size() > 0) && ($urandom_range(99) < p0);
        d0  = v0 ? q0[0] : 8'($urandom);
        v1  = (q1.size() > 0) && ($urandom_range(99) < p1);
        d1  = v1 ? q1[0] : 8'($urandom);
        @(negedge clk);
        if (frame_on && cyc > acc_t && cyc <= acc_t + FRAME) begin
            exp_busy = 1'b1;
            exp_tx   = frame[(cyc - acc_t - 1) / DIV_T];
        end else begin
            exp_busy = 1'b0;
            exp_tx   = 1'b1;
        end
        e0  = v0 && !(m_locked && m_lock_id);
        e1  = v1 && !(m_locked && !m_lock_id);
        any = (e0 || e1) && !do_rst && cyc >= free_at;
        s   = (e0 && e1) ? !m_last : e1;
        chk("ready0", req0_ready, any && !s);
        chk("ready1", req1_ready, any && s);
        chk("tx", tx, exp_tx);
        chk("busy", busy, exp_busy);
        chk("grant", grant, m_grant);
        if (req0_ready && v0) begin
            acc_cyc.push_back(cyc); acc_cl.push_back(1'b0); acc_dat.push_back(d0);
        end
        if (req1_ready && v1) begin
            acc_cyc.push_back(cyc); acc_cl.push_back(1'b1); acc_dat.push_back(d1);
        end
        if (busy === 1'b1) busy_cnt++;
        if (do_rst) begin
            frame_on   = 1'b0;
            free_at    = cyc + 1;
            m_last     = 1'b1;
            m_grant    = 1'b0;
            m_locked   = 1'b0;
            m_idle_cnt = 0;
        end else if (any) begin
            b          = s ? q1.pop_front() : q0.pop_front();
            frame      = {1'b1, b, 1'b0};
            frame_on   = 1'b1;
            acc_t      = cyc;
            free_at    = cyc + FRAME + 1;
            m_last     = s;
            m_grant    = s;
            m_locked   = LOCK_EN && (b != 8'h0A);
            m_lock_id  = s;
            m_idle_cnt = 0;
        end else if (m_locked && cyc >= free_at && !(m_lock_id ? v1 : v0)) begin
            m_idle_cnt++;
            if (m_idle_cnt == LOCK_T) begin
                m_locked   = 1'b0;
                m_idle_cnt = 0;
            end
        end else begin
            m_idle_cnt = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        v0  = 1'b0;
        v1  = 1'b0;
        d0  = '0;
        d1  = '0;
        @(posedge clk);
        #1;
        step(1'b1);
        step(1'b1);

        // Single byte 0x55 from client 0
        clear_logs();
        q0.push_back(8'h55);
        p0 = 100;
        t0 = cyc;
        repeat (45) step(1'b0);
        chk("t1_count", acc_cyc.size(), 1);
        chk("t1_accept_cycle", acc_cyc[0], t0);
        chk("t1_client", acc_cl[0], 1'b0);
        chk("t1_busy_cycles", busy_cnt, FRAME);
        chk("t1_rx_count", rx_q.size(), 1);
        chk("t1_rx_byte", rx_q[0], 8'h55);

        // Both clients continuously valid
        step(1'b1);
        clear_logs();
        q0 = '{8'hA1, 8'hA1};
        q1 = '{8'hB2, 8'hB2};
        p0 = 100;
        p1 = 100;
        repeat (4 * (FRAME + 1) + 4) step(1'b0);
        chk("t2_count", acc_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant_order", acc_cl[i], i % 2);
            chk("t2_rx_byte", rx_q[i], (i % 2) ? 8'hB2 : 8'hA1);
        end
        for (int i = 1; i < 4; i++) chk("t2_spacing", acc_cyc[i] - acc_cyc[i-1], FRAME + 1);

        // Client 1 alone: 0x00 then 0xFF
        step(1'b1);
        clear_logs();
        q1 = '{8'h00, 8'hFF};
        p0 = 0;
        p1 = 100;
        repeat (90) step(1'b0);
        chk("t3_count", acc_cyc.size(), 2);
        chk("t3_client", acc_cl[0] && acc_cl[1], 1'b1);
        chk("t3_spacing", acc_cyc[1] - acc_cyc[0], FRAME + 1);
        chk("t3_rx0", rx_q[0], 8'h00);
        chk("t3_rx1", rx_q[1], 8'hFF);

        // Reset during data bit 3, then a tie must go to client 0
        step(1'b1);
        clear_logs();
        q0 = '{8'hC3};
        p0 = 100;
        p1 = 0;
        repeat (18) step(1'b0);
        step(1'b1);
        t0 = cyc;
        q0 = '{8'h11};
        q1 = '{8'h22};
        p1 = 100;
        step(1'b0);
        chk("t4_aborted_not_decoded", rx_q.size(), 0);
        repeat (90) step(1'b0);
        chk("t4_count", acc_cyc.size(), 3);
        chk("t4_first_after_rst", acc_cyc[1], t0);
        chk("t4_tie_client0", acc_cl[1], 1'b0);
        chk("t4_then_client1", acc_cl[2], 1'b1);
        chk("t4_rx0", rx_q[0], 8'h11);
        chk("t4_rx1", rx_q[1], 8'h22);

        // Random traffic with valids dropping freely
        step(1'b1);
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            q0.push_back(8'($urandom));
            q1.push_back(8'($urandom));
        end
        p0 = $urandom_range(40, 90);
        p1 = $urandom_range(40, 90);
        repeat (1600) step(1'b0);
        chk("t5_q0_drained", q0.size(), 0);
        chk("t5_q1_drained", q1.size(), 0);
        chk("t5_rx_count", rx_q.size(), acc_dat.size());
        for (int i = 0; i < acc_dat.size(); i++) chk("t5_rx_byte", rx_q[i], acc_dat[i]);

`ifdef UART_ARB_LINE_LOCK_EN
        // "ab\n" from client 0 with client 1 always waiting
        step(1'b1);
        clear_logs();
        q0 = '{8'h61, 8'h62, 8'h0A};
        q1 = '{8'h77, 8'h77};
        p0 = 100;
        p1 = 100;
        repeat (5 * (FRAME + 1) + 4) step(1'b0);
        chk("l1_count", acc_cyc.size(), 5);
        for (int i = 0; i < 3; i++) chk("l1_locked_client0", acc_cl[i], 1'b0);
        chk("l1_client1_after_lf", acc_cl[3], 1'b1);
        chk("l1_no_timeout", acc_cyc[3] - acc_cyc[2], FRAME + 1);

        // "a" from client 0, then silence: lock must time out
        step(1'b1);
        clear_logs();
        q0 = '{8'h61};
        q1 = '{8'h77};
        repeat (FRAME + 1 + LOCK_T + 45) step(1'b0);
        chk("l2_count", acc_cyc.size(), 2);
        chk("l2_first_client0", acc_cl[0], 1'b0);
        chk("l2_second_client1", acc_cl[1], 1'b1);
        chk("l2_timeout_gap", acc_cyc[1] - acc_cyc[0], FRAME + 1 + LOCK_T);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
